// File: rtl/tcg_pkg.sv
// Shared types and constants for the touch colour grid: colour code layout
// and touch-panel coordinate width.
package tcg_pkg;

  typedef logic [2:0] colour_t;

  localparam int RED_BIT   = 0;
  localparam int BLUE_BIT  = 1;
  localparam int GREEN_BIT = 2;
  localparam int TP_W      = 12;

  // Power-on / cleared pattern: region i shows colour i mod 8.
  function automatic colour_t defaultColour(input int idx);
    return colour_t'(idx % 8);
  endfunction

endpackage

// File: rtl/tcg_region_decode.sv
// Maps a pixel coordinate onto a region index along one axis using a chain of
// threshold comparators; coordinates past the last threshold clamp to N-1.
module tcg_region_decode
  import tcg_pkg::*;
#(
  parameter int N     = 4,
  parameter int SIZE  = 200,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [9:0]       i_coord,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    o_idx = '0;
    for (int c = 1; c < N; c++) begin
      if (32'(i_coord) >= c * SIZE) begin
        o_idx = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/touch_colour_grid.sv
// Splits the LCD into a COLS x ROWS grid of colour regions; each accepted touch
// recolours the touched region through a two-stage update pipeline.
module touch_colour_grid
  import tcg_pkg::*;
#(
  parameter int COLS     = 4,
  parameter int ROWS     = 2,
  parameter int SCREEN_W = 800,
  parameter int SCREEN_H = 480,
  localparam int NR      = COLS * ROWS,
  localparam int NR_W    = (NR > 1) ? $clog2(NR) : 1
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic [9:0]      Pixel_X,
  input  logic [9:0]      Pixel_Y,
  input  logic            Touch_En,
  input  logic            Coord_En,
  input  logic [11:0]     TP_X,
  input  logic [11:0]     TP_Y,
  input  logic            Mode,
  input  logic [2:0]      Colour_In,
  input  logic            Clear,
  output logic [7:0]      Red,
  output logic [7:0]      Green,
  output logic [7:0]      Blue,
  output logic [NR_W-1:0] Region_Sel,
  output logic [2:0]      Region_Colour,
  output logic            Update_Pulse
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int RW    = SCREEN_W / COLS;
  localparam int RH    = SCREEN_H / ROWS;

  colour_t         r_colour [NR];
  logic [7:0]      r_red, r_green, r_blue;
  logic            r_armed;
  logic            r_s1Valid;
  logic [NR_W-1:0] r_s1Idx;
  logic            r_s1Mode;
  colour_t         r_s1ColourIn;
  logic            r_updatePulse;
  logic [NR_W-1:0] r_regionSel;
  colour_t         r_regionColour;

  logic [COL_W-1:0]  w_pixCol, w_touchCol;
  logic [ROW_W-1:0]  w_pixRow, w_touchRow;
  logic [NR_W-1:0]   w_pixIdx, w_touchIdx;
  logic [TP_W+3:0]   w_tpXScaled, w_tpYScaled;
  colour_t           w_pixColour, w_oldColour, w_newColour;
  logic              w_accept;

  tcg_region_decode #(.N(COLS), .SIZE(RW), .IDX_W(COL_W)) u_colDecode (
    .i_coord (Pixel_X),
    .o_idx   (w_pixCol)
  );

  tcg_region_decode #(.N(ROWS), .SIZE(RH), .IDX_W(ROW_W)) u_rowDecode (
    .i_coord (Pixel_Y),
    .o_idx   (w_pixRow)
  );

  assign w_pixIdx    = NR_W'(32'(w_pixRow) * COLS + 32'(w_pixCol));
  assign w_pixColour = r_colour[w_pixIdx];

  // Scaling the 12-bit panel coordinate by the grid size keeps the result in range.
  assign w_tpXScaled = (TP_W + 4)'(TP_X) * (TP_W + 4)'(COLS);
  assign w_tpYScaled = (TP_W + 4)'(TP_Y) * (TP_W + 4)'(ROWS);
  assign w_touchCol  = COL_W'(w_tpXScaled >> TP_W);
  assign w_touchRow  = ROW_W'(w_tpYScaled >> TP_W);
  assign w_touchIdx  = NR_W'(32'(w_touchRow) * COLS + 32'(w_touchCol));

  assign w_accept    = Coord_En & Touch_En & r_armed;
  assign w_oldColour = r_colour[r_s1Idx];
  assign w_newColour = r_s1Mode ? r_s1ColourIn : colour_t'(w_oldColour + 3'd1);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_red   <= 8'h00;
      r_green <= 8'h00;
      r_blue  <= 8'h00;
    end else begin
      r_red   <= {8{w_pixColour[RED_BIT]}};
      r_green <= {8{w_pixColour[GREEN_BIT]}};
      r_blue  <= {8{w_pixColour[BLUE_BIT]}};
    end
  end

  // Stage 1: arm/disarm per press and capture the touched region and mode.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_armed      <= 1'b1;
      r_s1Valid    <= 1'b0;
      r_s1Idx      <= '0;
      r_s1Mode     <= 1'b0;
      r_s1ColourIn <= '0;
    end else begin
      if (!Touch_En) begin
        r_armed <= 1'b1;
      end else if (w_accept) begin
        r_armed <= 1'b0;
      end
      r_s1Valid <= w_accept & ~(Clear & r_s1Valid);
      if (w_accept) begin
        r_s1Idx      <= w_touchIdx;
        r_s1Mode     <= Mode;
        r_s1ColourIn <= Colour_In;
      end
    end
  end

  // Stage 2: commit the colour; Clear overrides any write in flight.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NR; i++) begin
        r_colour[i] <= defaultColour(i);
      end
      r_updatePulse  <= 1'b0;
      r_regionSel    <= '0;
      r_regionColour <= '0;
    end else begin
      r_updatePulse <= 1'b0;
      if (Clear) begin
        for (int i = 0; i < NR; i++) begin
          r_colour[i] <= defaultColour(i);
        end
      end else if (r_s1Valid) begin
        r_colour[r_s1Idx] <= w_newColour;
        r_updatePulse     <= 1'b1;
        r_regionSel       <= r_s1Idx;
        r_regionColour    <= w_newColour;
      end
    end
  end

  assign Red           = r_red;
  assign Green         = r_green;
  assign Blue          = r_blue;
  assign Region_Sel    = r_regionSel;
  assign Region_Colour = r_regionColour;
  assign Update_Pulse  = r_updatePulse;

endmodule

// File: tb/tb_touch_colour_grid.sv
// Directed scoreboard bench for touch_colour_grid at the default 4x2 grid on an
// 800x480 screen.
module tb_touch_colour_grid;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int RW   = 200;
  localparam int RH   = 240;

  logic        Clock;
  logic        Resetn;
  logic [9:0]  Pixel_X, Pixel_Y;
  logic        Touch_En, Coord_En;
  logic [11:0] TP_X, TP_Y;
  logic        Mode;
  logic [2:0]  Colour_In;
  logic        Clear;
  logic [7:0]  Red, Green, Blue;
  logic [2:0]  Region_Sel;
  logic [2:0]  Region_Colour;
  logic        Update_Pulse;

  int errors = 0;
  int checks = 0;
  int model [COLS*ROWS];
  int rgbQ [$];
  int updQ [$];

  touch_colour_grid #(.COLS(COLS), .ROWS(ROWS), .SCREEN_W(800), .SCREEN_H(480)) dut (
    .Clock         (Clock),
    .Resetn        (Resetn),
    .Pixel_X       (Pixel_X),
    .Pixel_Y       (Pixel_Y),
    .Touch_En      (Touch_En),
    .Coord_En      (Coord_En),
    .TP_X          (TP_X),
    .TP_Y          (TP_Y),
    .Mode          (Mode),
    .Colour_In     (Colour_In),
    .Clear         (Clear),
    .Red           (Red),
    .Green         (Green),
    .Blue          (Blue),
    .Region_Sel    (Region_Sel),
    .Region_Colour (Region_Colour),
    .Update_Pulse  (Update_Pulse)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < COLS*ROWS; i++) model[i] = i % 8;
  endtask

  // Expected {R,G,B} for a pixel, checked one cycle after the pixel is presented.
  task automatic checkPixel(input int x, input int y);
    int c, r, code, e;
    c = x / RW;
    if (c > COLS - 1) c = COLS - 1;
    r = y / RH;
    if (r > ROWS - 1) r = ROWS - 1;
    code = model[r*COLS + c];
    e = (((code & 1) != 0) ? 32'hFF0000 : 32'h0) |
        (((code & 4) != 0) ? 32'h00FF00 : 32'h0) |
        (((code & 2) != 0) ? 32'h0000FF : 32'h0);
    rgbQ.push_back(e);
    Pixel_X = x[9:0];
    Pixel_Y = y[9:0];
    tick();
    checkOutput($sformatf("rgb_%0d_%0d", x, y), {8'h00, Red, Green, Blue}, rgbQ.pop_front());
  endtask

  task automatic rearm();
    Touch_En = 1'b0;
    tick();
    Touch_En = 1'b1;
  endtask

  // One accepted touch: expect the pulse exactly two edges after Coord_En.
  task automatic applyStimulus(input int tpx, input int tpy, input logic mode, input logic [2:0] cin);
    int col, row, idx, newC, e;
    col  = (tpx * COLS) >> 12;
    row  = (tpy * ROWS) >> 12;
    idx  = row * COLS + col;
    newC = mode ? int'(cin) : (model[idx] + 1) % 8;
    updQ.push_back(idx * 8 + newC);
    TP_X      = tpx[11:0];
    TP_Y      = tpy[11:0];
    Mode      = mode;
    Colour_In = cin;
    Coord_En  = 1'b1;
    tick();
    Coord_En = 1'b0;
    checkOutput("pulse_s1", {31'd0, Update_Pulse}, 32'd0);
    tick();
    checkOutput("pulse_s2", {31'd0, Update_Pulse}, 32'd1);
    e = updQ.pop_front();
    checkOutput("region_sel", {29'd0, Region_Sel}, e / 8);
    checkOutput("region_colour", {29'd0, Region_Colour}, e % 8);
    model[e / 8] = e % 8;
    tick();
    checkOutput("pulse_width", {31'd0, Update_Pulse}, 32'd0);
  endtask

  initial begin
    Resetn = 1'b0; Pixel_X = '0; Pixel_Y = '0; Touch_En = 1'b0; Coord_En = 1'b0;
    TP_X = '0; TP_Y = '0; Mode = 1'b0; Colour_In = '0; Clear = 1'b0;
    resetModel();
    tick();
    tick();
    checkOutput("rst_rgb", {8'h00, Red, Green, Blue}, 32'd0);
    checkOutput("rst_sel", {29'd0, Region_Sel}, 32'd0);
    checkOutput("rst_colour", {29'd0, Region_Colour}, 32'd0);
    checkOutput("rst_pulse", {31'd0, Update_Pulse}, 32'd0);
    Resetn = 1'b1;
    tick();

    checkPixel(250, 100);
    checkPixel(799, 479);
    checkPixel(0, 0);
    checkPixel(199, 239);
    checkPixel(200, 240);
    checkPixel(600, 0);

    Touch_En = 1'b1;
    applyStimulus(32'h900, 32'hA00, 1'b0, 3'd0);
    checkPixel(500, 300);

    TP_X = 12'h900; TP_Y = 12'hA00; Coord_En = 1'b1;
    tick();
    Coord_En = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("held_no_pulse", {31'd0, Update_Pulse}, 32'd0);
    end
    checkOutput("hold_sel", {29'd0, Region_Sel}, 32'd6);
    checkOutput("hold_colour", {29'd0, Region_Colour}, 32'd7);

    rearm();
    applyStimulus(32'h900, 32'hA00, 1'b0, 3'd0);
    checkPixel(500, 300);

    rearm();
    applyStimulus(32'h000, 32'h000, 1'b1, 3'd5);
    checkPixel(0, 0);

    rearm();
    applyStimulus(32'hFFF, 32'hFFF, 1'b0, 3'd0);
    checkPixel(799, 479);

    // Clear during the S2 cycle drops the write and restores the pattern.
    rearm();
    TP_X = 12'h500; TP_Y = 12'h100; Mode = 1'b0; Coord_En = 1'b1;
    tick();
    Coord_En = 1'b0;
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    resetModel();
    checkOutput("clear_no_pulse", {31'd0, Update_Pulse}, 32'd0);
    tick();
    checkOutput("clear_no_pulse_late", {31'd0, Update_Pulse}, 32'd0);
    checkOutput("clear_hold_sel", {29'd0, Region_Sel}, 32'd7);
    checkOutput("clear_hold_colour", {29'd0, Region_Colour}, 32'd0);
    checkPixel(0, 0);
    checkPixel(500, 300);
    checkPixel(250, 100);

    // Reset one cycle after an accepted touch discards the pending write.
    rearm();
    applyStimulus(32'h900, 32'hA00, 1'b0, 3'd0);
    rearm();
    TP_X = 12'h100; TP_Y = 12'h100; Coord_En = 1'b1;
    tick();
    Coord_En = 1'b0;
    Resetn = 1'b0;
    resetModel();
    tick();
    checkOutput("midrst_pulse", {31'd0, Update_Pulse}, 32'd0);
    Resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("postrst_no_pulse", {31'd0, Update_Pulse}, 32'd0);
    end
    checkOutput("postrst_sel", {29'd0, Region_Sel}, 32'd0);
    checkOutput("postrst_colour", {29'd0, Region_Colour}, 32'd0);
    checkPixel(500, 300);
    checkPixel(0, 0);

    applyStimulus(32'h900, 32'hA00, 1'b0, 3'd0);
    checkPixel(500, 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
